// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared defaults, state encoding and lane slicing for the systolic array feeder
package sys_arr_pkg;
   localparam int WIDTH_HEIGHT = 8;
   localparam int DATA_W = 4;
   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
   function automatic int lane_lsb(input int r, input int w);
      return r * w;
   endfunction
endpackage

// File: rtl/sa_input_skewer_if.sv
// sa_input_skewer_if: activation handshake in, skewed array drive out
interface sa_input_skewer_if import sys_arr_pkg::*; #(
   parameter int width_height = WIDTH_HEIGHT,
   parameter int data_w = DATA_W
);
   logic in_valid;
   logic in_ready;
   logic [width_height*data_w-1:0] in_data;
   logic in_last;
   logic [width_height*data_w-1:0] data_out;
   logic active_out;
   logic tile_done;
   logic busy;
   modport master (
      output in_valid, in_data, in_last,
      input in_ready, data_out, active_out, tile_done, busy
   );
   modport slave (
      input in_valid, in_data, in_last,
      output in_ready, data_out, active_out, tile_done, busy
   );
endinterface

// File: rtl/sa_lane_delay.sv
// sa_lane_delay: fixed-depth shift register for one skew lane
module sa_lane_delay #(
   parameter int depth = 1,
   parameter int data_w = 4
) (
   input logic clk,
   input logic rst_n,
   input logic [data_w-1:0] d,
   output logic [data_w-1:0] q
);
   logic [data_w-1:0] sr [depth];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr <= '{default: '0};
      else begin
         sr[0] <= d;
         for (int i = 1; i < depth; i++) sr[i] <= sr[i-1];
      end
   end
   assign q = sr[depth-1];
endmodule

// File: rtl/sa_input_skewer.sv
// sa_input_skewer: diagonally skews activation vectors into the array and drains each tile
module sa_input_skewer import sys_arr_pkg::*; #(
   parameter int width_height = WIDTH_HEIGHT,
   parameter int data_w = DATA_W
) (
   input logic clk,
   input logic rst_n,
   sa_input_skewer_if.slave bus
);
   localparam int cnt_w = $clog2(width_height);
   localparam int vec_w = width_height * data_w;
   state_t state, state_nxt;
   logic [cnt_w-1:0] cnt, cnt_nxt;
   logic ready, fire, done_nxt, active_q, done_q;
   logic [vec_w-1:0] skew_in, skew_out;
   assign ready = state != FLUSH;
   assign fire = bus.in_valid & ready;
   // idle slots shift zeros so unused triangle positions stay clean
   assign skew_in = fire ? bus.in_data : '0;
   for (genvar r = 0; r < width_height; r++) begin : g_lane
      sa_lane_delay #(.depth(r + 1), .data_w(data_w)) u_dly (
         .clk(clk),
         .rst_n(rst_n),
         .d(skew_in[lane_lsb(r, data_w) +: data_w]),
         .q(skew_out[lane_lsb(r, data_w) +: data_w])
      );
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         active_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         active_q <= fire;
         done_q <= done_nxt;
      end
   end
   // flush ends when the last element reaches the top lane
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      done_nxt = 1'b0;
      unique case (state)
         IDLE, STREAM: if (fire) begin
            state_nxt = bus.in_last ? FLUSH : STREAM;
            cnt_nxt = cnt_w'(width_height - 1);
         end
         FLUSH: begin
            cnt_nxt = cnt - cnt_w'(1);
            if (cnt == cnt_w'(1)) begin
               state_nxt = IDLE;
               done_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
   assign bus.in_ready = ready;
   assign bus.data_out = skew_out;
   assign bus.active_out = active_q;
   assign bus.tile_done = done_q;
   assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_sa_input_skewer.sv
// tb_sa_input_skewer: scoreboard bench with a cycle-timestamped model of the skew rules
module tb_sa_input_skewer;
   import sys_arr_pkg::*;
   localparam int WH = WIDTH_HEIGHT;
   localparam int DW = DATA_W;
   localparam int VW = WH * DW;
   typedef struct {int t; logic [DW-1:0] v;} lane_item_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int last_e = -1000;
   bit open_t = 1'b0;
   lane_item_t lq [WH][$];
   int aq [$];
   int dq [$];
   logic [VW-1:0] vecs [16];

   sa_input_skewer_if #(.width_height(WH), .data_w(DW)) bus ();
   sa_input_skewer #(.width_height(WH), .data_w(DW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // model: element accepted at edge E shows on lane r in cycle E+r; done at E_last+WH-1
   always @(negedge clk) begin : mon
      logic [VW-1:0] ev;
      logic ea, ed, er, eb;
      if (!rst_n) begin
         for (int r = 0; r < WH; r++) lq[r].delete();
         aq.delete();
         dq.delete();
         last_e = -1000;
         open_t = 1'b0;
         chk("rst_data", 64'(bus.data_out), 64'd0);
         chk("rst_active", 64'(bus.active_out), 64'd0);
         chk("rst_done", 64'(bus.tile_done), 64'd0);
         chk("rst_ready", 64'(bus.in_ready), 64'd1);
         chk("rst_busy", 64'(bus.busy), 64'd0);
      end else begin
         ev = '0;
         for (int r = 0; r < WH; r++)
            if (lq[r].size() > 0 && lq[r][0].t == cyc) begin
               ev[r*DW +: DW] = lq[r][0].v;
               void'(lq[r].pop_front());
            end
         ea = aq.size() > 0 && aq[0] == cyc;
         if (ea) void'(aq.pop_front());
         ed = dq.size() > 0 && dq[0] == cyc;
         if (ed) void'(dq.pop_front());
         er = !(cyc >= last_e && cyc <= last_e + WH - 2);
         eb = open_t || !er;
         chk("data_out", 64'(bus.data_out), 64'(ev));
         chk("active_out", 64'(bus.active_out), 64'(ea));
         chk("tile_done", 64'(bus.tile_done), 64'(ed));
         chk("in_ready", 64'(bus.in_ready), 64'(er));
         chk("busy", 64'(bus.busy), 64'(eb));
         if (er && bus.in_valid) begin
            for (int r = 0; r < WH; r++) lq[r].push_back('{t: cyc + 1 + r, v: bus.in_data[r*DW +: DW]});
            aq.push_back(cyc + 1);
            if (bus.in_last) begin
               dq.push_back(cyc + WH);
               last_e = cyc + 1;
               open_t = 1'b0;
            end else open_t = 1'b1;
         end
      end
   end

   task automatic step(input logic v, input logic [VW-1:0] d, input logic l);
      bus.in_valid = v;
      bus.in_data = d;
      bus.in_last = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, VW'($urandom), 1'b1);
   endtask

   task automatic send(input int lo, input int hi, input bit fin);
      for (int k = lo; k <= hi; k++) begin
         int guard;
         logic acc;
         guard = 0;
         do begin
            acc = bus.in_ready;
            step(1'b1, vecs[k], fin && k == hi);
            guard++;
         end while (!acc && guard < 50);
         chk("send_accept", 64'(acc), 64'd1);
      end
   endtask

   task automatic ramp_vec0();
      for (int r = 0; r < WH; r++) vecs[0][r*DW +: DW] = DW'(r + 1);
   endtask

   initial begin
      int left;
      bus.in_valid = 1'b1;
      bus.in_data = VW'($urandom);
      bus.in_last = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      ramp_vec0();
      send(0, 0, 1'b1);
      repeat (6) step(1'b1, VW'($urandom), 1'b1);
      idle(10);
      vecs[0] = VW'(1);
      for (int k = 1; k < 8; k++) vecs[k] = VW'($urandom);
      send(0, 7, 1'b1);
      idle(16);
      send(0, 2, 1'b0);
      idle(2);
      send(3, 7, 1'b1);
      idle(16);
      for (int k = 0; k < 16; k++) vecs[k] = VW'($urandom);
      send(0, 3, 1'b1);
      send(4, 6, 1'b1);
      idle(12);
      send(8, 8, 1'b1);
      idle(2);
      rst_n = 1'b0;
      repeat (2) step(1'b1, VW'($urandom), 1'b0);
      rst_n = 1'b1;
      ramp_vec0();
      send(0, 0, 1'b1);
      idle(12);
      repeat (400) step($urandom_range(0, 9) < 7, VW'($urandom), $urandom_range(0, 4) == 0);
      idle(20);
      left = aq.size() + dq.size();
      for (int r = 0; r < WH; r++) left += lq[r].size();
      chk("leftover", 64'(left), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sa_input_skewer.md
Name: sa_input_skewer

Overview:
- Upstream feeder for the weight-stationary systolic array. Accepts one activation vector per cycle (one element per array row) over a valid/ready handshake.
- Applies the diagonal skew: lane r is delayed r cycles relative to lane 0. Drives the array's data_in and active inputs.
- Drains the skew after each tile, then signals tile_done. The controller reloads weights only after tile_done.

Parameters:
- width_height, 8, number of array rows (lanes); must be ≥2
- data_w, 4, bits per activation element

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  in_data/in_last valid
- in_ready  out  1  skewer can accept a vector this cycle
- in_data  in  width_height*data_w  lane r occupies bits [r*data_w +: data_w]; lane 0 is LSBs
- in_last  in  1  qualifies the final vector of a tile
- data_out  out  width_height*data_w  skewed vector to array data_in, same lane packing
- active_out  out  1  to array active; high when lane 0 of data_out carries an accepted element
- tile_done  out  1  one-cycle pulse when the last element of a tile leaves lane width_height-1
- busy  out  1  high in STREAM or FLUSH

Behaviour:
- Reset values: data_out=0, active_out=0, tile_done=0, busy=0, in_ready=1, state=IDLE, all delay stages=0. Async assert; deassert is synchronised to clk.
- fire = in_valid & in_ready.
- Lane r has r+1 register stages. An element accepted at edge E appears on lane r from edge E+r onward, for one cycle.
- Lane 0 latency is 1 cycle; lane width_height-1 latency is width_height cycles.
- Bubble (no fire while in STREAM): a zero vector enters all lanes, and active_out is 0 for that slot. Lane alignment is preserved.
- Zero vs. valid: lanes carry 0 whenever no valid element occupies the slot. Upper-triangle slots during fill and lower-triangle slots during drain are 0.
- active_out is the registered copy of fire, aligned with lane 0.
- States:
  - IDLE: in_ready=1. A fire with in_last=0 goes to STREAM. A fire with in_last=1 goes to FLUSH (single-vector tile).
  - STREAM: in_ready=1. A fire with in_last=1 goes to FLUSH.
  - FLUSH: in_ready=0. A down-counter is loaded with width_height-1 on entry and decrements each cycle. Zeros are shifted in. When the counter reaches 0, go to IDLE.
- tile_done is registered and asserts in the cycle the last tile element is on lane width_height-1, i.e. after edge E_last+width_height-1. It coincides with the IDLE return, when in_ready=1 again.
- Back-to-back tiles: a new fire in the same cycle tile_done is high is legal. The new element enters lane 0 while draining completes.
- in_data and in_last are ignored when in_valid=0. in_last is also ignored when not fired.
- Reset mid-operation: all pipeline contents are discarded immediately and state returns to IDLE. No tile_done is issued for the aborted tile.
- No arithmetic is performed; element values pass through unchanged, unsigned, width data_w.

Decomposition:
- Shared package sys_arr_pkg:
  - default width_height and data_w
  - state enum {IDLE, STREAM, FLUSH}
  - lane-slice helper constants
- One sub-module, sa_lane_delay: a parameterised-depth data_w-bit shift register with async active-low reset, instantiated once per lane in a generate loop with depth r+1.

Test Plan:
- Reset check: hold rst_n=0 with in_valid=1 → data_out=0, active_out=0, in_ready=1, busy=0.
- Single-vector tile: in_data lanes {r: r+1}={1..8}, in_last=1 → lane r shows r+1 exactly one cycle, at r+1 cycles after fire. active_out is high 1 cycle. in_ready is low 7 cycles. tile_done pulses with lane 7=8.
- 8-vector tile: vectors V0..V7 with V0={0,0,0,0,0,0,0,1}, streamed contiguously, last on V7 → at cycle k after first fire, lane r = V(k-1-r)[r], otherwise 0. Reconstructed output equals the textbook diagonal pattern (lane0 1,4,5,2,7,4,2,0 …). tile_done occurs 15 cycles after the first fire.
- Bubble: drop in_valid for 2 cycles between V2 and V3 → all lanes carry zero in those slots, active_out is low for 2 cycles, and lane alignment is preserved.
- Back-to-back tiles: second tile's first fire in the tile_done cycle → no lost or duplicated element, and a second tile_done at the correct offset.
- Reset mid-FLUSH: assert rst_n=0 three cycles into FLUSH → outputs clear immediately and there is no tile_done. After release, a fresh single-vector tile behaves as in the single-vector test.
